// File: rtl/uart_rx_sampler.sv
// UART receive front end: synchronises rx, qualifies start bits, samples data
// bits at mid-bit and assembles frames with valid / framing-error pulses.
module uart_rx_sampler #(
    parameter int unsigned CLKS_PER_BIT = 10416,
    parameter int unsigned DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 rx,
    output logic                 LD,
    output logic                 dIn,
    output logic [DATA_BITS-1:0] data,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int unsigned CNT_W   = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W   = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int unsigned CNT_MID = CLKS_PER_BIT / 2 - 1;
    localparam int unsigned CNT_END = CLKS_PER_BIT - 1;
    localparam int unsigned IDX_END = DATA_BITS - 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t               r_state;
    logic                 r_rx_m;
    logic                 r_rx_s;
    logic [CNT_W-1:0]     r_cnt;
    logic [IDX_W-1:0]     r_idx;
    logic [DATA_BITS-1:0] r_sh;
    logic [DATA_BITS-1:0] r_data;
    logic                 r_ld;
    logic                 r_din;
    logic                 r_dv;
    logic                 r_fe;
    logic                 r_busy;

    logic w_cnt_mid;
    logic w_cnt_end;

    assign w_cnt_mid = (r_cnt == CNT_W'(CNT_MID));
    assign w_cnt_end = (r_cnt == CNT_W'(CNT_END));

    // Two-flop synchroniser; idles high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_m <= 1'b1;
            r_rx_s <= 1'b1;
        end else begin
            r_rx_m <= rx;
            r_rx_s <= r_rx_m;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_sh    <= '0;
            r_data  <= '0;
            r_ld    <= 1'b0;
            r_din   <= 1'b0;
            r_dv    <= 1'b0;
            r_fe    <= 1'b0;
            r_busy  <= 1'b0;
        end else begin
            r_ld   <= 1'b0;
            r_dv   <= 1'b0;
            r_fe   <= 1'b0;
            r_cnt  <= r_cnt + CNT_W'(1);
            // Lags state by one cycle so busy spans the data_valid/frame_err cycle.
            r_busy <= (r_state != S_IDLE);

            case (r_state)
                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (w_cnt_mid) begin
                        r_cnt <= '0;
                        if (!r_rx_s) begin
                            r_idx   <= '0;
                            r_state <= S_DATA;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end

                S_DATA: begin
                    if (w_cnt_end) begin
                        r_cnt <= '0;
                        r_sh  <= DATA_BITS'({r_rx_s, r_sh} >> 1);
                        r_din <= r_rx_s;
                        r_ld  <= 1'b1;
                        if (r_idx == IDX_W'(IDX_END)) begin
                            r_state <= S_STOP;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end

                S_STOP: begin
                    if (w_cnt_end) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_data  <= r_sh;
                            r_dv    <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_fe    <= 1'b1;
                            r_state <= S_BREAK;
                        end
                    end
                end

                S_BREAK: begin
                    r_cnt <= '0;
                    if (r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                default: begin
                    r_cnt   <= '0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign LD         = r_ld;
    assign dIn        = r_din;
    assign data       = r_data;
    assign data_valid = r_dv;
    assign frame_err  = r_fe;
    assign busy       = r_busy;

endmodule
